// File: rtl/cfg_register_file_if.sv
// cfg_register_file_if: local bus (CEb/WEb/REb strobes) between a bus master and the config register file
interface cfg_register_file_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   ADDR;
    logic [DATA_W-1:0]   DATA_IN;
    logic [DATA_W/8-1:0] BEb;
    logic                CEb;
    logic                WEb;
    logic                REb;
    logic [DATA_W-1:0]   DATA_OUT;
    logic                ACK;

    modport master (output ADDR, DATA_IN, BEb, CEb, WEb, REb, input DATA_OUT, ACK);
    modport slave (input ADDR, DATA_IN, BEb, CEb, WEb, REb, output DATA_OUT, ACK);
endinterface

// File: rtl/cfg_register_file.sv
// cfg_register_file: double-buffered config registers (shadow written by bus, active updated on COMMIT); optional parity via CFG_PARITY_EN
module cfg_register_file #(
    parameter int                N_REGS    = 16,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 18,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 18'h100,
    parameter int                RST_LEN   = 16,
    parameter logic [DATA_W-1:0] ID_WORD   = 32'h4D50_4434,
    parameter logic [DATA_W-1:0] DUMMY     = 32'hDEAD_BEEF
) (
    input  logic                     RSTb,
    input  logic                     CLK,
    cfg_register_file_if.slave       bus,
    output logic                     USER_RESET,
    output logic                     COMMIT,
    output logic [N_REGS*DATA_W-1:0] REGS_OUT,
    output logic                     PARITY_ERR
);
    localparam int                NB     = DATA_W / 8;
    localparam int                IW     = $clog2(N_REGS);
    localparam logic [ADDR_W-1:0] NR     = ADDR_W'(N_REGS);
    localparam logic [ADDR_W-1:0] CTRL_A = BASE_ADDR + NR;
    localparam logic [ADDR_W-1:0] STAT_A = CTRL_A + ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ID_A   = CTRL_A + ADDR_W'(2);

    logic                     ce_prev;
    logic                     start;
    logic                     wr;
    logic                     rd;
    logic                     user_hit;
    logic                     ctrl_wr;
    logic                     do_commit;
    logic                     dirty;
    logic [ADDR_W-1:0]        off;
    logic [IW-1:0]            idx;
    logic [DATA_W-1:0]        shadow [N_REGS];
    logic [DATA_W-1:0]        wdat;
    logic [DATA_W-1:0]        rdat;
    logic [DATA_W-1:0]        status;
    logic [N_REGS*DATA_W-1:0] active;
    logic [7:0]               cnt;

    // An access starts only on the first strobed cycle of a CEb assertion
    assign start     = !bus.CEb && (!bus.WEb || !bus.REb) && ce_prev;
    assign wr        = start && !bus.WEb;
    assign rd        = start && bus.WEb;
    assign off       = bus.ADDR - BASE_ADDR;
    assign user_hit  = (bus.ADDR >= BASE_ADDR) && (off < NR);
    assign idx       = off[IW-1:0];
    assign ctrl_wr   = wr && (bus.ADDR == CTRL_A) && !bus.BEb[0];
    assign do_commit = ctrl_wr && bus.DATA_IN[1];
    assign USER_RESET = cnt != 8'd0;
    assign REGS_OUT  = active;
    assign status    = DATA_W'({PARITY_ERR, USER_RESET, dirty});

    // Byte-enable merge of bus data into the addressed shadow word
    always_comb begin
        wdat = shadow[idx];
        for (int k = 0; k < NB; k++)
            if (!bus.BEb[k]) wdat[k*8 +: 8] = bus.DATA_IN[k*8 +: 8];
    end

    // Read mux; CTRL is write-only and reads back as zero
    always_comb begin
        rdat = user_hit ? shadow[idx] :
               (bus.ADDR == STAT_A) ? status :
               (bus.ADDR == ID_A) ? ID_WORD :
               (bus.ADDR == CTRL_A) ? '0 : DUMMY;
    end

    // Bus handshake, read data, pulse counter and dirty flag; ce_prev resets high so the first access after reset can start
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            ce_prev      <= 1'b1;
            bus.ACK      <= 1'b0;
            bus.DATA_OUT <= '0;
            COMMIT       <= 1'b0;
            cnt          <= 8'd0;
            dirty        <= 1'b0;
        end else begin
            ce_prev <= bus.CEb;
            bus.ACK <= start;
            COMMIT  <= do_commit;
            if (rd) bus.DATA_OUT <= rdat;
            cnt   <= (ctrl_wr && bus.DATA_IN[0]) ? 8'(RST_LEN) : USER_RESET ? cnt - 8'd1 : cnt;
            dirty <= (wr && user_hit) ? 1'b1 : do_commit ? 1'b0 : dirty;
        end
    end

    // Shadow words take bus writes; active words copy all shadows at once on commit
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            for (int i = 0; i < N_REGS; i++) shadow[i] <= '0;
            active <= '0;
        end else begin
            if (wr && user_hit) shadow[idx] <= wdat;
            if (do_commit)
                for (int i = 0; i < N_REGS; i++) active[i*DATA_W +: DATA_W] <= shadow[i];
        end
    end

`ifdef CFG_PARITY_EN
    logic [N_REGS-1:0] sh_par;
    logic [N_REGS-1:0] ac_par;
    logic              mism;
    logic              perr;

    assign PARITY_ERR = perr;

    // Any active word whose stored even-parity bit disagrees with its data
    always_comb begin
        mism = 1'b0;
        for (int i = 0; i < N_REGS; i++) mism |= ^{active[i*DATA_W +: DATA_W], ac_par[i]};
    end

    // Parity bits follow their words; the error is sticky until cleared through CTRL bit2
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            sh_par <= '0;
            ac_par <= '0;
            perr   <= 1'b0;
        end else begin
            if (wr && user_hit) sh_par[idx] <= ^wdat;
            if (do_commit) ac_par <= sh_par;
            perr <= (ctrl_wr && bus.DATA_IN[2]) ? 1'b0 : perr | mism;
        end
    end
`else
    assign PARITY_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_cfg_register_file.sv
// tb_cfg_register_file: directed vector table plus hand sequences for commit, user reset pulse, held CEb and async reset
module tb_cfg_register_file;
    localparam int                N    = 16;
    localparam int                DW   = 32;
    localparam int                AW   = 18;
    localparam logic [AW-1:0]     BASE = 18'h100;
    localparam logic [AW-1:0]     CTRL = 18'h110;
    localparam logic [AW-1:0]     STAT = 18'h111;
    localparam logic [AW-1:0]     IDA  = 18'h112;

    logic              CLK = 1'b0;
    logic              RSTb = 1'b0;
    logic              USER_RESET;
    logic              COMMIT;
    logic              PARITY_ERR;
    logic [N*DW-1:0]   REGS_OUT;
    int                n_cmp = 0;
    int                n_bad = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0]    be;
        logic          we;
        logic          re;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tv [15];

    always #5 CLK = ~CLK;

    cfg_register_file_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cfg_register_file dut (
        .RSTb       (RSTb),
        .CLK        (CLK),
        .bus        (bus),
        .USER_RESET (USER_RESET),
        .COMMIT     (COMMIT),
        .REGS_OUT   (REGS_OUT),
        .PARITY_ERR (PARITY_ERR)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge, one cycle after the start edge
    task automatic acc(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be,
                       input logic we, input logic re, output logic ack);
        bus.ADDR = a;
        bus.DATA_IN = d;
        bus.BEb = be;
        bus.WEb = we;
        bus.REb = re;
        bus.CEb = 1'b0;
        @(negedge CLK);
        ack = bus.ACK;
        bus.CEb = 1'b1;
        bus.WEb = 1'b1;
        bus.REb = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic ack;
        int   n;
`ifdef CFG_PARITY_EN
        logic [N*DW-1:0] v;
`endif
        tv[0]  = '{IDA,         32'h0,         4'h0, 1'b1, 1'b0, 32'h4D50_4434};
        tv[1]  = '{BASE + 3,    32'h1234_5678, 4'hC, 1'b0, 1'b1, 32'h4D50_4434};
        tv[2]  = '{BASE + 3,    32'h0,         4'h0, 1'b1, 1'b0, 32'h0000_5678};
        tv[3]  = '{STAT,        32'h0,         4'h0, 1'b1, 1'b0, 32'h0000_0001};
        tv[4]  = '{CTRL,        32'h0,         4'h0, 1'b1, 1'b0, 32'h0000_0000};
        tv[5]  = '{18'h3FFFF,   32'h0,         4'h0, 1'b1, 1'b0, 32'hDEAD_BEEF};
        tv[6]  = '{18'h3FFFF,   32'h1,         4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF};
        tv[7]  = '{18'h3FFFF,   32'h0,         4'h0, 1'b1, 1'b0, 32'hDEAD_BEEF};
        tv[8]  = '{BASE,        32'hAABB_CCDD, 4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF};
        tv[9]  = '{BASE,        32'h1122_3344, 4'h5, 1'b0, 1'b1, 32'hDEAD_BEEF};
        tv[10] = '{BASE,        32'h0,         4'h0, 1'b1, 1'b0, 32'h11BB_33DD};
        tv[11] = '{BASE + 1,    32'hCAFE_F00D, 4'h0, 1'b0, 1'b0, 32'h11BB_33DD};
        tv[12] = '{BASE + 1,    32'h0,         4'h0, 1'b1, 1'b0, 32'hCAFE_F00D};
        tv[13] = '{18'h0FF,     32'h0,         4'h0, 1'b1, 1'b0, 32'hDEAD_BEEF};
        tv[14] = '{IDA + 1,     32'h0,         4'h0, 1'b1, 1'b0, 32'hDEAD_BEEF};

        bus.ADDR = '0;
        bus.DATA_IN = '0;
        bus.BEb = 4'hF;
        bus.CEb = 1'b1;
        bus.WEb = 1'b1;
        bus.REb = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_dout", bus.DATA_OUT, 0);
        chk("rst_ack", bus.ACK, 0);
        chk("rst_regs", {63'b0, |REGS_OUT}, 0);
        chk("rst_ureset", USER_RESET, 0);
        chk("rst_commit", COMMIT, 0);
        chk("rst_perr", PARITY_ERR, 0);
        RSTb = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            chk($sformatf("vec%0d_ack_idle", i), bus.ACK, 0);
            acc(tv[i].a, tv[i].d, tv[i].be, tv[i].we, tv[i].re, ack);
            chk($sformatf("vec%0d_ack", i), ack, 1);
            chk($sformatf("vec%0d_dout", i), bus.DATA_OUT, tv[i].exp);
        end

        @(negedge CLK);
        chk("precommit_reg3", REGS_OUT[3*DW +: DW], 0);
        chk("precommit_reg0", REGS_OUT[0 +: DW], 0);
        acc(CTRL, 32'h2, 4'h0, 1'b0, 1'b1, ack);
        chk("commit_pulse", COMMIT, 1);
        chk("commit_reg3", REGS_OUT[3*DW +: DW], 32'h0000_5678);
        chk("commit_reg0", REGS_OUT[0 +: DW], 32'h11BB_33DD);
        chk("commit_reg1", REGS_OUT[1*DW +: DW], 32'hCAFE_F00D);
        @(negedge CLK);
        chk("commit_one_cycle", COMMIT, 0);
        acc(STAT, 32'h0, 4'h0, 1'b1, 1'b0, ack);
        chk("status_after_commit", bus.DATA_OUT, 0);

        @(negedge CLK);
        acc(CTRL, 32'h1, 4'h0, 1'b0, 1'b1, ack);
        n = int'(USER_RESET);
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (!USER_RESET) break;
            n++;
        end
        chk("ureset_len", n, 16);
        chk("ureset_keeps_regs", REGS_OUT[3*DW +: DW], 32'h0000_5678);

        @(negedge CLK);
        acc(CTRL, 32'h1, 4'h0, 1'b0, 1'b1, ack);
        n = int'(USER_RESET);
        repeat (9) begin
            @(negedge CLK);
            n += int'(USER_RESET);
        end
        acc(CTRL, 32'h1, 4'h0, 1'b0, 1'b1, ack);
        chk("retrig_ack", ack, 1);
        n += int'(USER_RESET);
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (!USER_RESET) break;
            n++;
        end
        chk("ureset_retrig_len", n, 26);

        @(negedge CLK);
        bus.ADDR = BASE + 2;
        bus.DATA_IN = 32'h55;
        bus.BEb = 4'h0;
        bus.WEb = 1'b0;
        bus.REb = 1'b1;
        bus.CEb = 1'b0;
        n = 0;
        repeat (5) begin
            @(negedge CLK);
            n += int'(bus.ACK);
        end
        bus.CEb = 1'b1;
        bus.WEb = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            n += int'(bus.ACK);
        end
        chk("held_ce_acks", n, 1);
        acc(BASE + 2, 32'h0, 4'h0, 1'b1, 1'b0, ack);
        chk("held_ce_data", bus.DATA_OUT, 32'h55);

        @(negedge CLK);
        acc(CTRL, 32'h1, 4'h0, 1'b0, 1'b1, ack);
        @(negedge CLK);
        acc(STAT, 32'h0, 4'h0, 1'b1, 1'b0, ack);
        chk("status_dirty_ureset", bus.DATA_OUT, 32'h3);
        @(negedge CLK);
        bus.ADDR = IDA;
        bus.WEb = 1'b1;
        bus.REb = 1'b0;
        bus.CEb = 1'b0;
        @(posedge CLK);
        #1 RSTb = 1'b0;
        @(negedge CLK);
        chk("arst_ack", bus.ACK, 0);
        chk("arst_dout", bus.DATA_OUT, 0);
        chk("arst_ureset", USER_RESET, 0);
        chk("arst_commit", COMMIT, 0);
        chk("arst_regs", {63'b0, |REGS_OUT}, 0);
        bus.CEb = 1'b1;
        bus.REb = 1'b1;
        @(negedge CLK);
        RSTb = 1'b1;
        @(negedge CLK);
        chk("arst_no_late_ack", bus.ACK, 0);
        acc(BASE + 2, 32'h0, 4'h0, 1'b1, 1'b0, ack);
        chk("arst_shadow_cleared", bus.DATA_OUT, 0);

`ifdef CFG_PARITY_EN
        @(negedge CLK);
        acc(BASE, 32'h0000_00F1, 4'h0, 1'b0, 1'b1, ack);
        @(negedge CLK);
        acc(CTRL, 32'h2, 4'h0, 1'b0, 1'b1, ack);
        @(negedge CLK);
        chk("par_clean", PARITY_ERR, 0);
        v = dut.active;
        v[5] = ~v[5];
        force dut.active = v;
        repeat (2) @(negedge CLK);
        chk("par_err_set", PARITY_ERR, 1);
        release dut.active;
        acc(STAT, 32'h0, 4'h0, 1'b1, 1'b0, ack);
        chk("par_status_bit2", bus.DATA_OUT, 32'h4);
        @(negedge CLK);
        acc(CTRL, 32'h2, 4'h0, 1'b0, 1'b1, ack);
        @(negedge CLK);
        chk("par_sticky", PARITY_ERR, 1);
        acc(CTRL, 32'h4, 4'h0, 1'b0, 1'b1, ack);
        chk("par_cleared", PARITY_ERR, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
